sobel_gray_feeder: RTL and testbench

//  Upstream stage of sobel_unit: turns 512-bit host lines (16 RGBA8888 pixels)

---
 rtl/sobel_pkg.sv | 36 +++
 rtl/sobel_gray_feeder_if.sv | 29 ++
 rtl/sobel_luma_lane.sv | 51 +++++
 rtl/sobel_gray_feeder.sv | 145 ++++++++++++++
 tb/tb_sobel_gray_feeder.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the grayscale feeder in front of sobel_unit.
//   PIXELS      : pixels per beat (32-bit RGBA in, 8-bit luma out)
//   FLUSH_BEATS : zero beats appended per frame to drain sobel_unit's delay line
//   CNT_W       : beat counter width
package sobel_pkg;

  localparam int unsigned PIXELS      = 16;
  localparam int unsigned FLUSH_BEATS = 32;
  localparam int unsigned CNT_W       = 32;

  localparam int unsigned PIX_W  = 32;
  localparam int unsigned LUMA_W = 8;
  // 77*255 + 150*255 + 29*255 + 128 = 65408, so 16 bits never overflow
  localparam int unsigned PROD_W = 16;

  localparam int unsigned COEF_R    = 77;
  localparam int unsigned COEF_G    = 150;
  localparam int unsigned COEF_B    = 29;
  localparam int unsigned LUMA_RND  = 128;

  // Packed so that r lands in bits [7:0] of each 32-bit host pixel
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } rgba_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DRAIN  = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/sobel_gray_feeder_if.sv
// Host-side bus of sobel_gray_feeder: frame control, RGBA input stream,
// luma output stream and status.
//   master : host / consumer side
//   slave  : the feeder
interface sobel_gray_feeder_if;
  import sobel_pkg::*;

  logic                       start;
  logic [CNT_W-1:0]           frame_beats;
  logic                       in_valid;
  logic [PIXELS*PIX_W-1:0]    in_data;
  logic                       in_ready;
  logic                       out_valid;
  logic [PIXELS*LUMA_W-1:0]   out_data;
  logic                       out_ready;
  logic                       busy;
  logic                       done;

  modport master (
    output start, frame_beats, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, done
  );

  modport slave (
    input  start, frame_beats, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done
  );

endinterface

// File: rtl/sobel_luma_lane.sv
// One pixel of the RGBA -> luma converter, two register stages.
//   clk, rst_b : clock, async active-low reset
//   i_en       : stage enable (pipeline advance)
//   i_pix      : RGBA8888 pixel (alpha ignored)
//   o_y        : registered luma, (77R + 150G + 29B + 128) >> 8
module sobel_luma_lane
  import sobel_pkg::*;
(
  input  logic              clk,
  input  logic              rst_b,
  input  logic              i_en,
  input  rgba_t             i_pix,
  output logic [LUMA_W-1:0] o_y
);

  logic [PROD_W-1:0] r_prod_r;
  logic [PROD_W-1:0] r_prod_g;
  logic [PROD_W-1:0] r_prod_b;
  logic [LUMA_W-1:0] r_y;
  logic [PROD_W-1:0] w_sum;
  logic              w_unused_alpha;

  assign w_unused_alpha = ^i_pix.a;

  // Stage 1: weighted channels
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_prod_r <= '0;
      r_prod_g <= '0;
      r_prod_b <= '0;
    end else if (i_en) begin
      r_prod_r <= PROD_W'(COEF_R) * PROD_W'(i_pix.r);
      r_prod_g <= PROD_W'(COEF_G) * PROD_W'(i_pix.g);
      r_prod_b <= PROD_W'(COEF_B) * PROD_W'(i_pix.b);
    end
  end

  assign w_sum = r_prod_r + r_prod_g + r_prod_b + PROD_W'(LUMA_RND);

  // Stage 2: rounded sum, keep the top byte
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_y <= '0;
    end else if (i_en) begin
      r_y <= w_sum[PROD_W-1 -: LUMA_W];
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/sobel_gray_feeder.sv
// Converts 512-bit RGBA host lines into 128-bit luma beats for sobel_unit,
// appends FLUSH_BEATS zero beats per frame and pulses done once the last
// beat has been accepted downstream.
//   clk   : clock
//   rst_b : async active-low reset
//   bus   : slave side of sobel_gray_feeder_if (start/frame_beats, in_*, out_*,
//           busy, done)
module sobel_gray_feeder
  import sobel_pkg::*;
(
  input logic                 clk,
  input logic                 rst_b,
  sobel_gray_feeder_if.slave  bus
);

  // FLUSH_BEATS must be a power of two >= 2 for this counter width
  localparam int unsigned FLUSH_W = $clog2(FLUSH_BEATS);

  feeder_state_e        r_state;
  feeder_state_e        w_next;
  logic [CNT_W-1:0]     r_left;
  logic [FLUSH_W-1:0]   r_flush_cnt;
  logic                 r_v1;
  logic                 r_v2;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_advance;
  logic                 w_in_fire;
  logic                 w_flush_fire;
  logic                 w_inject;
  logic                 w_out_fire;
  logic                 w_last_in;
  logic                 w_flush_last;
  logic                 w_drain_last;
  logic                 w_start;
  logic [PIXELS*PIX_W-1:0]  w_s1_data;
  logic [LUMA_W-1:0]        w_y [PIXELS];
  logic [PIXELS*LUMA_W-1:0] w_out_data;

  // Whole pipeline moves together; holds only when the output is stuck
  assign w_advance    = !r_v2 || bus.out_ready;
  assign w_start      = (r_state == ST_IDLE) && bus.start;
  assign w_in_fire    = (r_state == ST_STREAM) && w_advance && bus.in_valid;
  assign w_flush_fire = (r_state == ST_FLUSH) && w_advance;
  assign w_inject     = w_in_fire || w_flush_fire;
  assign w_out_fire   = r_v2 && bus.out_ready;
  assign w_last_in    = w_in_fire && (r_left == CNT_W'(1));
  assign w_flush_last = w_flush_fire && (r_flush_cnt == FLUSH_W'(FLUSH_BEATS - 1));
  // Nothing is injected after FLUSH, so the final beat is the one with S1 empty
  assign w_drain_last = w_out_fire && !r_v1;

  // Flush beats are zero pixels, giving Y = 0
  assign w_s1_data = (r_state == ST_STREAM) ? bus.in_data : '0;

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next = (bus.frame_beats == '0) ? ST_FLUSH : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_last_in) w_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (w_flush_last) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_drain_last) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register with registered busy/done decodes
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= (r_state == ST_DRAIN) && (w_next == ST_IDLE);
    end
  end

  // Remaining input lines and injected flush beats
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_left      <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_start) begin
        r_left <= bus.frame_beats;
      end else if (w_in_fire) begin
        r_left <= r_left - CNT_W'(1);
      end
      if (r_state == ST_IDLE) begin
        r_flush_cnt <= '0;
      end else if (w_flush_fire) begin
        r_flush_cnt <= r_flush_cnt + FLUSH_W'(1);
      end
    end
  end

  // Valid bits tracking the two lane stages
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else if (w_advance) begin
      r_v1 <= w_inject;
      r_v2 <= r_v1;
    end
  end

  for (genvar i = 0; i < PIXELS; i++) begin : g_lane
    sobel_luma_lane u_lane (
      .clk   (clk),
      .rst_b (rst_b),
      .i_en  (w_advance),
      .i_pix (rgba_t'(w_s1_data[i*PIX_W +: PIX_W])),
      .o_y   (w_y[i])
    );
  end

  // Pack lane outputs, lane i at bits [8i +: 8]
  always_comb begin
    w_out_data = '0;
    for (int i = 0; i < PIXELS; i++) begin
      w_out_data[i*LUMA_W +: LUMA_W] = w_y[i];
    end
  end

  assign bus.in_ready  = w_advance && (r_state == ST_STREAM);
  assign bus.out_valid = r_v2;
  assign bus.out_data  = w_out_data;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_sobel_gray_feeder.sv
module tb_sobel_gray_feeder;
  import sobel_pkg::*;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  sobel_gray_feeder_if bus();

  sobel_gray_feeder dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [511:0] src_q[$];
  logic [127:0] obs_q[$];
  int done_cnt, rdy_hi_cnt, viol_cnt, mon_cyc, last_out_cyc, done_cyc;

  // Observation point, 2 time units after the falling edge
  task automatic sample();
    mon_cyc++;
    if (bus.out_valid && bus.out_ready) begin
      obs_q.push_back(bus.out_data);
      last_out_cyc = mon_cyc;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = mon_cyc;
    end
    if (bus.in_ready) rdy_hi_cnt++;
    if (bus.in_ready && bus.out_valid && !bus.out_ready) viol_cnt++;
  endtask

  task automatic step();
    #2;
    sample();
    @(negedge clk);
  endtask

  task automatic clear_mon();
    obs_q.delete();
    done_cnt = 0; rdy_hi_cnt = 0; viol_cnt = 0;
    last_out_cyc = -1; done_cyc = -1;
  endtask

  // Gray pixels R=G=B=base+j in lane j, alpha junk; luma equals the gray level
  function automatic logic [511:0] gray_line(input logic [7:0] base);
    logic [511:0] l;
    for (int j = 0; j < 16; j++) l[32*j +: 32] = {8'hA5, {3{8'(base + 8'(j))}}};
    return l;
  endfunction

  function automatic logic [127:0] gray_beat(input logic [7:0] base);
    logic [127:0] b;
    for (int j = 0; j < 16; j++) b[8*j +: 8] = 8'(base + 8'(j));
    return b;
  endfunction

  function automatic logic [127:0] luma_model(input logic [511:0] d);
    logic [127:0] y;
    logic [31:0]  p;
    int unsigned  s;
    for (int i = 0; i < 16; i++) begin
      p = d[32*i +: 32];
      s = 77 * p[7:0] + 150 * p[15:8] + 29 * p[23:16] + 128;
      y[8*i +: 8] = 8'(s >> 8);
    end
    return y;
  endfunction

  function automatic logic [127:0] obs_at(input int k);
    if (k < obs_q.size()) return obs_q[k];
    return 'x;
  endfunction

  // rmode: 0 ready always, 1 ready pattern 1,0,0, 2 random; vmode: 0 dense, 1 random
  task automatic drive_frame(input int unsigned n, input int rmode, input int vmode,
                             input int restart_at, output bit timed_out);
    int idx = 0;
    bus.start = 1'b1; bus.frame_beats = n; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    bus.start = 1'b0;
    timed_out = 1'b1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 3 == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      bus.start       = (cyc == restart_at);
      bus.frame_beats = (cyc == restart_at) ? 32'd7 : n;
      bus.in_valid    = (idx < src_q.size()) && (vmode == 0 || $urandom_range(0, 1) == 1);
      bus.in_data     = (idx < src_q.size()) ? src_q[idx] : '0;
      #2;
      sample();
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.done) timed_out = 1'b0;
      @(negedge clk);
      if (!timed_out) break;
    end
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    bus.start = 1'b0; bus.frame_beats = '0; bus.in_valid = 1'b0;
    bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_miss++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_vec++; if (bus.in_ready !== 1'b0) begin n_miss++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    n_vec++; if (bus.out_data !== 128'h0) begin n_miss++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    @(negedge clk);
    rst_b = 1'b1;
    step(); step();
  endtask

  task automatic test_single_white();
    bit to;
    logic [511:0] l;
    l = '0; l[31:0] = 32'h00FFFFFF;
    src_q.delete(); src_q.push_back(l);
    clear_mon();
    drive_frame(1, 0, 0, -1, to);
    n_vec++; if (to) begin n_miss++; $display("FAIL white_timeout: no done within budget"); end
    n_vec++; if (obs_q.size() !== 33) begin n_miss++; $display("FAIL white_count: got %0d want 33", obs_q.size()); end
    n_vec++; if (obs_at(0) !== 128'hFF) begin n_miss++; $display("FAIL white_beat0: got %h want %h", obs_at(0), 128'hFF); end
    for (int k = 1; k < 33; k++) begin
      n_vec++; if (obs_at(k) !== 128'h0) begin n_miss++; $display("FAIL white_flush%0d: got %h want 0", k, obs_at(k)); end
    end
    n_vec++; if (done_cnt !== 1) begin n_miss++; $display("FAIL white_done_cnt: got %0d want 1", done_cnt); end
    n_vec++; if (done_cyc !== last_out_cyc + 1) begin n_miss++; $display("FAIL white_done_timing: got cyc %0d want %0d", done_cyc, last_out_cyc + 1); end
  endtask

  task automatic test_coeffs();
    bit to;
    src_q.delete();
    src_q.push_back({16{32'hFF0000FF}});
    src_q.push_back({16{32'h0000FF00}});
    src_q.push_back({16{32'h00FF0000}});
    clear_mon();
    drive_frame(3, 0, 0, -1, to);
    n_vec++; if (to) begin n_miss++; $display("FAIL coef_timeout: no done within budget"); end
    n_vec++; if (obs_at(0) !== {16{8'h4D}}) begin n_miss++; $display("FAIL coef_red: got %h want %h", obs_at(0), {16{8'h4D}}); end
    n_vec++; if (obs_at(1) !== {16{8'h95}}) begin n_miss++; $display("FAIL coef_green: got %h want %h", obs_at(1), {16{8'h95}}); end
    n_vec++; if (obs_at(2) !== {16{8'h1D}}) begin n_miss++; $display("FAIL coef_blue: got %h want %h", obs_at(2), {16{8'h1D}}); end
    n_vec++; if (obs_q.size() !== 35) begin n_miss++; $display("FAIL coef_count: got %0d want 35", obs_q.size()); end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [7:0] bases [4];
    bases = '{8'h11, 8'h22, 8'h33, 8'h44};
    src_q.delete();
    for (int i = 0; i < 4; i++) src_q.push_back(gray_line(bases[i]));
    clear_mon();
    drive_frame(4, 1, 0, -1, to);
    n_vec++; if (to) begin n_miss++; $display("FAIL bp_timeout: no done within budget"); end
    n_vec++; if (obs_q.size() !== 36) begin n_miss++; $display("FAIL bp_count: got %0d want 36", obs_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (obs_at(i) !== gray_beat(bases[i])) begin n_miss++; $display("FAIL bp_beat%0d: got %h want %h", i, obs_at(i), gray_beat(bases[i])); end
    end
    for (int k = 4; k < 36; k++) begin
      n_vec++; if (obs_at(k) !== 128'h0) begin n_miss++; $display("FAIL bp_flush%0d: got %h want 0", k, obs_at(k)); end
    end
    n_vec++; if (viol_cnt !== 0) begin n_miss++; $display("FAIL bp_in_ready_stall: got %0d cycles want 0", viol_cnt); end
    n_vec++; if (done_cnt !== 1) begin n_miss++; $display("FAIL bp_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_zero_frame();
    bit to;
    src_q.delete();
    clear_mon();
    drive_frame(0, 0, 0, -1, to);
    n_vec++; if (to) begin n_miss++; $display("FAIL zero_timeout: no done within budget"); end
    n_vec++; if (obs_q.size() !== 32) begin n_miss++; $display("FAIL zero_count: got %0d want 32", obs_q.size()); end
    for (int k = 0; k < 32; k++) begin
      n_vec++; if (obs_at(k) !== 128'h0) begin n_miss++; $display("FAIL zero_beat%0d: got %h want 0", k, obs_at(k)); end
    end
    n_vec++; if (rdy_hi_cnt !== 0) begin n_miss++; $display("FAIL zero_in_ready: high %0d cycles want 0", rdy_hi_cnt); end
    n_vec++; if (done_cnt !== 1) begin n_miss++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_start_ignored();
    bit to;
    src_q.delete();
    for (int i = 0; i < 3; i++) src_q.push_back(gray_line(8'(8'h50 + 8'(i * 16))));
    clear_mon();
    drive_frame(3, 0, 1, 1, to);
    n_vec++; if (to) begin n_miss++; $display("FAIL restart_timeout: no done within budget"); end
    n_vec++; if (obs_q.size() !== 35) begin n_miss++; $display("FAIL restart_count: got %0d want 35", obs_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (obs_at(i) !== gray_beat(8'(8'h50 + 8'(i * 16)))) begin n_miss++; $display("FAIL restart_beat%0d: got %h want %h", i, obs_at(i), gray_beat(8'(8'h50 + 8'(i * 16)))); end
    end
    n_vec++; if (done_cnt !== 1) begin n_miss++; $display("FAIL restart_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_flush();
    bit to;
    clear_mon();
    bus.start = 1'b1; bus.frame_beats = 32'd1; bus.out_ready = 1'b1;
    step();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = gray_line(8'h20);
    step();
    bus.in_valid = 1'b0;
    repeat (8) step();
    #1;
    n_vec++; if (bus.busy !== 1'b1) begin n_miss++; $display("FAIL midrst_busy_before: got %b want 1", bus.busy); end
    n_vec++; if (bus.out_valid !== 1'b1) begin n_miss++; $display("FAIL midrst_valid_before: got %b want 1", bus.out_valid); end
    @(posedge clk); #2;
    rst_b = 1'b0;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.busy !== 1'b0) begin n_miss++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    done_cnt = 0;
    repeat (3) step();
    rst_b = 1'b1;
    repeat (40) step();
    n_vec++; if (done_cnt !== 0) begin n_miss++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt); end
    src_q.delete();
    src_q.push_back(gray_line(8'h60));
    src_q.push_back(gray_line(8'h70));
    clear_mon();
    drive_frame(2, 0, 0, -1, to);
    n_vec++; if (to) begin n_miss++; $display("FAIL postrst_timeout: no done within budget"); end
    n_vec++; if (obs_q.size() !== 34) begin n_miss++; $display("FAIL postrst_count: got %0d want 34", obs_q.size()); end
    n_vec++; if (obs_at(0) !== gray_beat(8'h60)) begin n_miss++; $display("FAIL postrst_beat0: got %h want %h", obs_at(0), gray_beat(8'h60)); end
    n_vec++; if (obs_at(1) !== gray_beat(8'h70)) begin n_miss++; $display("FAIL postrst_beat1: got %h want %h", obs_at(1), gray_beat(8'h70)); end
    n_vec++; if (done_cnt !== 1) begin n_miss++; $display("FAIL postrst_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_random_frame();
    bit to;
    logic [511:0] l;
    int bad = 0;
    src_q.delete();
    for (int i = 0; i < 1000; i++) begin
      for (int w = 0; w < 16; w++) l[32*w +: 32] = $urandom();
      src_q.push_back(l);
    end
    clear_mon();
    drive_frame(1000, 2, 1, -1, to);
    n_vec++; if (to) begin n_miss++; $display("FAIL rand_timeout: no done within budget"); end
    n_vec++; if (obs_q.size() !== 1032) begin n_miss++; $display("FAIL rand_count: got %0d want 1032", obs_q.size()); end
    for (int k = 0; k < 1032; k++) begin
      logic [127:0] e;
      e = (k < 1000) ? luma_model(src_q[k]) : 128'h0;
      n_vec++;
      if (obs_at(k) !== e) begin
        n_miss++;
        bad++;
        if (bad <= 5) $display("FAIL rand_beat%0d: got %h want %h", k, obs_at(k), e);
      end
    end
    n_vec++; if (viol_cnt !== 0) begin n_miss++; $display("FAIL rand_in_ready_stall: got %0d cycles want 0", viol_cnt); end
    n_vec++; if (done_cnt !== 1) begin n_miss++; $display("FAIL rand_done_cnt: got %0d want 1", done_cnt); end
  endtask

  initial begin
    mon_cyc = 0;
    clear_mon();
    test_reset();
    test_single_white();
    test_coeffs();
    test_backpressure();
    test_zero_frame();
    test_start_ignored();
    test_reset_mid_flush();
    test_random_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
